// File: rtl/icache_fetcher.sv
// Instruction fetch stage with a direct-mapped instruction cache.
// A hit returns the instruction one cycle after the request. A miss fetches
// the whole line from program memory, fills the cache, and then returns the
// requested word.
module icache_fetcher #(
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
    parameter int unsigned CACHE_SIZE            = 16,
    parameter int unsigned LINE_SIZE             = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       fetch_req,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0]           fetch_pc,
    output logic                                       fetch_ready,
    output logic [PROGRAM_MEM_DATA_BITS-1:0]           instruction,
    output logic                                       program_mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]           program_mem_read_address,
    input  logic                                       program_mem_read_ready,
    input  logic [LINE_SIZE*PROGRAM_MEM_DATA_BITS-1:0] program_mem_read_data,
    output logic [15:0]                                hit_count,
    output logic [15:0]                                miss_count
);

    localparam int unsigned NUM_LINES = CACHE_SIZE / LINE_SIZE;
    localparam int unsigned OFF_BITS  = $clog2(LINE_SIZE);
    localparam int unsigned IDX_BITS  = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS  = PROGRAM_MEM_ADDR_BITS - IDX_BITS - OFF_BITS;
    localparam int unsigned DW        = PROGRAM_MEM_DATA_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
    logic [DW-1:0]         data_mem [NUM_LINES][LINE_SIZE];
    logic [OFF_BITS-1:0]   off_q;

    logic [OFF_BITS-1:0]   pc_off;
    logic [IDX_BITS-1:0]   pc_idx;
    logic [TAG_BITS-1:0]   pc_tag;
    logic                  lookup_hit;
    logic [IDX_BITS-1:0]   miss_idx;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  fill_en;
    logic [DW-1:0]         fill_words [LINE_SIZE];

    // Split the requested PC and the outstanding line address into fields.
    always_comb begin
        pc_off     = fetch_pc[OFF_BITS-1:0];
        pc_idx     = fetch_pc[OFF_BITS +: IDX_BITS];
        pc_tag     = fetch_pc[PROGRAM_MEM_ADDR_BITS-1 -: TAG_BITS];
        lookup_hit = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
        miss_idx   = program_mem_read_address[OFF_BITS +: IDX_BITS];
        miss_tag   = program_mem_read_address[PROGRAM_MEM_ADDR_BITS-1 -: TAG_BITS];
        fill_en    = (state == MISS) && program_mem_read_ready && !reset;
    end

    // Unpack the wide line read into words, word 0 at the LSB.
    always_comb begin
        for (int k = 0; k < int'(LINE_SIZE); k++) begin
            fill_words[k] = program_mem_read_data[k*DW +: DW];
        end
    end

    // Tag and data storage; contents are qualified by valid_q, so no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[miss_idx] <= miss_tag;
            for (int k = 0; k < int'(LINE_SIZE); k++) begin
                data_mem[miss_idx][k] <= fill_words[k];
            end
        end
    end

    // Fetch FSM with registered outputs, valid bits and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                    <= IDLE;
            fetch_ready              <= 1'b0;
            instruction              <= '0;
            program_mem_read_valid   <= 1'b0;
            program_mem_read_address <= '0;
            valid_q                  <= '0;
            off_q                    <= '0;
            hit_count                <= 16'd0;
            miss_count               <= 16'd0;
        end else begin
            fetch_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        if (lookup_hit) begin
                            instruction <= data_mem[pc_idx][pc_off];
                            fetch_ready <= 1'b1;
                            if (hit_count != 16'hFFFF) begin
                                hit_count <= hit_count + 16'd1;
                            end
                            state <= DONE;
                        end else begin
                            program_mem_read_valid   <= 1'b1;
                            program_mem_read_address <= {pc_tag, pc_idx, OFF_BITS'(0)};
                            off_q                    <= pc_off;
                            if (miss_count != 16'hFFFF) begin
                                miss_count <= miss_count + 16'd1;
                            end
                            state <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (program_mem_read_ready) begin
                        valid_q[miss_idx]      <= 1'b1;
                        instruction            <= fill_words[off_q];
                        program_mem_read_valid <= 1'b0;
                        fetch_ready            <= 1'b1;
                        state                  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetcher.sv
// Scoreboard bench for icache_fetcher: a driver predicts hit/miss from a
// line-level cache model and expected words from a flat program memory; a
// controller model answers line reads; a monitor checks each completion.
module tb_icache_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [7:0]  fetch_pc;
    logic        fetch_ready;
    logic [15:0] instruction;
    logic        program_mem_read_valid;
    logic [7:0]  program_mem_read_address;
    logic        program_mem_read_ready;
    logic [63:0] program_mem_read_data;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    icache_fetcher dut (
        .clk                      (clk),
        .reset                    (reset),
        .fetch_req                (fetch_req),
        .fetch_pc                 (fetch_pc),
        .fetch_ready              (fetch_ready),
        .instruction              (instruction),
        .program_mem_read_valid   (program_mem_read_valid),
        .program_mem_read_address (program_mem_read_address),
        .program_mem_read_ready   (program_mem_read_ready),
        .program_mem_read_data    (program_mem_read_data),
        .hit_count                (hit_count),
        .miss_count               (miss_count)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] hits;
        logic [15:0] misses;
    } exp_t;

    logic [15:0] mem [256];
    exp_t        sb_q [$];
    logic [7:0]  addr_q [$];

    // Reference cache: which program line (pc >> 2) each of the 4 slots holds.
    bit          m_valid [4];
    int          m_line  [4];
    logic [15:0] m_hits, m_misses;

    int  n_checks = 0;
    int  n_fails  = 0;
    bit  ctl_hold = 1'b0;
    bit  stray_en = 1'b0;
    int  ctl_delay_fix = -1;
    bit  prev_keep = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = -1;
        end
        m_hits   = 16'd0;
        m_misses = 16'd0;
    endtask

    // Issue one fetch (caller sits at a negedge) and wait for its completion.
    task automatic do_fetch(input logic [7:0] pc, input bit keep);
        int   idx;
        bit   hit;
        int   n;
        exp_t e;
        idx = int'(pc[3:2]);
        hit = m_valid[idx] && (m_line[idx] == int'(pc[7:2]));
        if (hit) begin
            if (m_hits != 16'hFFFF) m_hits = m_hits + 16'd1;
        end else begin
            if (m_misses != 16'hFFFF) m_misses = m_misses + 16'd1;
            m_valid[idx] = 1'b1;
            m_line[idx]  = int'(pc[7:2]);
            addr_q.push_back({pc[7:2], 2'b00});
        end
        e.instr  = mem[pc];
        e.hits   = m_hits;
        e.misses = m_misses;
        sb_q.push_back(e);
        fetch_pc  = pc;
        fetch_req = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (fetch_ready) break;
        end
        if (!fetch_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL fetch_timeout: pc 0x%0h got no fetch_ready, required within 100 cycles", pc);
        end else if (hit) begin
            check("hit_latency", 32'(n), prev_keep ? 32'd2 : 32'd1);
        end
        if (!keep) fetch_req = 1'b0;
        prev_keep = keep;
    endtask

    // Program-memory controller model: answers each line read after a delay.
    initial begin : controller
        bit          pending;
        bit          chk_next;
        int          dly;
        logic [7:0]  a;
        pending  = 1'b0;
        chk_next = 1'b0;
        dly      = 0;
        program_mem_read_ready = 1'b0;
        program_mem_read_data  = '0;
        forever begin
            @(negedge clk);
            if (ctl_hold) begin
                pending  = 1'b0;
                chk_next = 1'b0;
                continue;
            end
            program_mem_read_ready = 1'b0;
            if (reset) begin
                pending  = 1'b0;
                chk_next = 1'b0;
                continue;
            end
            if (chk_next) begin
                check("fill_fetch_ready", 32'(fetch_ready), 32'd1);
                check("fill_valid_drop", 32'(program_mem_read_valid), 32'd0);
                chk_next = 1'b0;
            end
            if (program_mem_read_valid && !pending) begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_read: address 0x%0h, required no request", program_mem_read_address);
                end else begin
                    check("read_addr", 32'(program_mem_read_address), 32'(addr_q.pop_front()));
                end
                pending = 1'b1;
                dly = (ctl_delay_fix >= 0) ? ctl_delay_fix : int'($urandom_range(0, 4));
            end else if (pending) begin
                if (dly == 0) begin
                    for (int k = 0; k < 4; k++) begin
                        a = program_mem_read_address + 8'(k);
                        program_mem_read_data[k*16 +: 16] = mem[a];
                    end
                    program_mem_read_ready = 1'b1;
                    pending  = 1'b0;
                    chk_next = 1'b1;
                end else begin
                    dly--;
                end
            end else if (stray_en && !program_mem_read_valid && ($urandom_range(0, 7) == 0)) begin
                program_mem_read_data  = {$urandom, $urandom};
                program_mem_read_ready = 1'b1;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every fetch_ready.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && fetch_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_ready: instruction 0x%0h, required no completion", instruction);
                end else begin
                    e = sb_q.pop_front();
                    check("instruction", 32'(instruction), 32'(e.instr));
                    check("hit_count", 32'(hit_count), 32'(e.hits));
                    check("miss_count", 32'(miss_count), 32'(e.misses));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit saw;
        bit bad;
        bit keep;
        logic [7:0] pc;

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h04] = 16'h1111;
        mem[8'h05] = 16'h2222;
        mem[8'h06] = 16'h3333;
        mem[8'h07] = 16'h4444;
        model_reset();

        reset     = 1'b1;
        fetch_req = 1'b0;
        fetch_pc  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check("rst_instruction", 32'(instruction), 32'd0);
        check("rst_read_valid", 32'(program_mem_read_valid), 32'd0);
        check("rst_read_addr", 32'(program_mem_read_address), 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_miss_count", 32'(miss_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, hit after fill, then a conflicting tag on index 1.
        ctl_delay_fix = 2;
        do_fetch(8'h05, 1'b0);
        check("cold_miss_word", 32'(instruction), 32'h2222);
        @(negedge clk);
        do_fetch(8'h07, 1'b0);
        check("hit_word", 32'(instruction), 32'h4444);
        @(negedge clk);
        ctl_delay_fix = -1;
        do_fetch(8'h15, 1'b0);
        @(negedge clk);
        do_fetch(8'h05, 1'b0);
        check("conflict_refetch_misses", 32'(miss_count), 32'd3);
        @(negedge clk);

        // Reset while a line read is outstanding; late ready must be ignored.
        ctl_hold  = 1'b1;
        fetch_pc  = 8'h09;
        fetch_req = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20 && !saw; i++) begin
            @(negedge clk);
            saw = program_mem_read_valid;
        end
        check("midmiss_valid_seen", 32'(saw), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midmiss_valid_drop", 32'(program_mem_read_valid), 32'd0);
        check("midmiss_no_ready", 32'(fetch_ready), 32'd0);
        reset     = 1'b0;
        fetch_req = 1'b0;
        program_mem_read_data  = {$urandom, $urandom};
        program_mem_read_ready = 1'b1;
        @(negedge clk);
        program_mem_read_ready = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (fetch_ready || program_mem_read_valid) bad = 1'b1;
        end
        check("late_ready_ignored", 32'(bad), 32'd0);
        check("midmiss_counters", {hit_count, miss_count}, 32'd0);
        ctl_hold = 1'b0;
        model_reset();
        do_fetch(8'h05, 1'b0);
        check("post_reset_miss", 32'(miss_count), 32'd1);
        @(negedge clk);

        // Address wrap at the top of program memory.
        do_fetch(8'hFF, 1'b0);
        @(negedge clk);

        // Back-to-back hits with fetch_req held, stray readies allowed.
        stray_en = 1'b1;
        do_fetch(8'h04, 1'b1);
        do_fetch(8'h05, 1'b1);
        do_fetch(8'h06, 1'b1);
        do_fetch(8'h07, 1'b0);
        @(negedge clk);

        // Randomized traffic, mostly in a small window so hits and conflicts mix.
        for (int t = 0; t < 300; t++) begin
            pc   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 47));
            keep = ($urandom_range(0, 2) == 0);
            do_fetch(pc, keep);
            if (!keep) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        if (prev_keep) begin
            do_fetch(8'h05, 1'b0);
            @(negedge clk);
        end

        // Hit counter saturation.
        stray_en = 1'b0;
        do_fetch(8'h05, 1'b0);
        @(negedge clk);
        force dut.hit_count = 16'hFFFF;
        @(negedge clk);
        release dut.hit_count;
        m_hits = 16'hFFFF;
        @(negedge clk);
        do_fetch(8'h05, 1'b0);
        check("hit_saturated", 32'(hit_count), 32'hFFFF);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("read_queue_drained", 32'(addr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
